tcdm_master_shim: RTL and testbench

- Master-side adapter placed between one core/accelerator port and one input of the radix-2 butterfly TCDM network.
- Converts the core's valid/ready request and response channels to the network's req/gnt protocol. The network's response is rvld/rdata, returned exactly one cycle after gnt, and it cannot be stalled.
- Buffers requests and responses, and uses a credit counter to limit outstanding transactions, so a response can never be lost when the core back-pressures.

---
 rtl/tcdm_shim_pkg.sv | 20 ++
 rtl/tcdm_shim_fifo.sv | 65 ++++++
 rtl/tcdm_master_shim.sv | 154 +++++++++++++++
 tb/tb_tcdm_master_shim.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_shim_pkg.sv
// Shared definitions for the TCDM master shim.
//   - ShimAddWidth / ShimReqDataWidth : native widths of the network port
//   - req_entry_t                     : request entry {add, data} at native widths
//   - depth_ok()                      : elaboration check for FIFO depths
package tcdm_shim_pkg;

  localparam int unsigned ShimAddWidth     = 5;
  localparam int unsigned ShimReqDataWidth = 32;

  typedef struct packed {
    logic [ShimAddWidth-1:0]     add;
    logic [ShimReqDataWidth-1:0] data;
  } req_entry_t;

  // A FIFO needs at least one entry to hold anything.
  function automatic logic depth_ok(input int unsigned depth);
    return depth >= 32'd1;
  endfunction

endpackage

// File: rtl/tcdm_shim_fifo.sv
// Registered FIFO without fall-through: a word pushed in cycle N is visible
// at o_data in cycle N+1 at the earliest.
//   i_clk, i_rst      : clock, synchronous active-high reset (pointers/count)
//   i_push, i_data    : write port; a push while full is taken only with a pop
//   i_pop             : read strobe; ignored while empty
//   o_data            : head entry (don't-care while o_empty)
//   o_full, o_empty   : occupancy flags
//   o_usage           : number of stored entries
module tcdm_shim_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CntW-1:0]  o_usage
);

  localparam int unsigned     PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_usage = r_count;
  assign o_data  = r_mem[r_rptr];

  // When full, the slot under the write pointer is the head being popped.
  assign w_push = i_push & (~o_full | i_pop);
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == LastPtr) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only; it is not reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/tcdm_master_shim.sv
// Master-side adapter between a core valid/ready port and one input of the
// TCDM butterfly network (req/gnt, response rvld one cycle after gnt).
//   clk_i, rst_i                     : clock, synchronous active-high reset
//   req_valid_i/req_ready_o          : core request handshake
//   req_add_i, req_data_i            : core request address / payload
//   resp_valid_o/resp_ready_i        : core response handshake
//   resp_data_o                      : response FIFO head
//   net_req_o/net_gnt_i              : network request / grant
//   net_add_o, net_data_o            : request FIFO head
//   net_rvld_i, net_rdata_i          : network response (cannot be stalled)
//   outstanding_o                    : credits in use
//   err_o                            : sticky protocol error
module tcdm_master_shim
  import tcdm_shim_pkg::*;
#(
  parameter int unsigned AddWidth      = ShimAddWidth,
  parameter int unsigned ReqDataWidth  = ShimReqDataWidth,
  parameter int unsigned RespDataWidth = 32,
  parameter int unsigned ReqDepth      = 2,
  parameter int unsigned RespDepth     = 2,
  parameter int unsigned CntWidth      = $clog2(RespDepth + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [AddWidth-1:0]      req_add_i,
  input  logic [ReqDataWidth-1:0]  req_data_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [RespDataWidth-1:0] resp_data_o,
  output logic                     net_req_o,
  input  logic                     net_gnt_i,
  output logic [AddWidth-1:0]      net_add_o,
  output logic [ReqDataWidth-1:0]  net_data_o,
  input  logic [RespDataWidth-1:0] net_rdata_i,
  input  logic                     net_rvld_i,
  output logic [CntWidth-1:0]      outstanding_o,
  output logic                     err_o
);

  if (!depth_ok(ReqDepth) || !depth_ok(RespDepth)) begin : g_bad_depth
    $error("tcdm_master_shim: ReqDepth and RespDepth must be >= 1");
  end

  // Same layout as req_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [AddWidth-1:0]     add;
    logic [ReqDataWidth-1:0] data;
  } req_ent_t;

  localparam int unsigned ReqUseW  = $clog2(ReqDepth + 1);
  localparam int unsigned RespUseW = $clog2(RespDepth + 1);

  req_ent_t              w_req_in;
  req_ent_t              w_req_head;
  logic                  w_req_full;
  logic                  w_req_empty;
  logic [ReqUseW-1:0]    w_req_usage;
  logic                  w_resp_full;
  logic                  w_resp_empty;
  logic [RespUseW-1:0]   w_resp_usage;
  logic                  w_grant;
  logic                  w_resp_pop;
  logic                  w_rvld_take;
  logic                  w_rvld_bad;
  logic [CntWidth-1:0]   r_cnt;
  logic                  r_err;
  logic                  r_rst_d;

  assign w_req_in = '{add: req_add_i, data: req_data_i};

  tcdm_shim_fifo #(
    .WIDTH ($bits(req_ent_t)),
    .DEPTH (ReqDepth),
    .CntW  (ReqUseW)
  ) u_req_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (req_valid_i & req_ready_o),
    .i_data  (w_req_in),
    .i_pop   (w_grant),
    .o_data  (w_req_head),
    .o_full  (w_req_full),
    .o_empty (w_req_empty),
    .o_usage (w_req_usage)
  );

  assign req_ready_o = ~w_req_full;
  assign net_add_o   = w_req_head.add;
  assign net_data_o  = w_req_head.data;

  // Issue only from registered state, so no path from gnt or core inputs.
  assign net_req_o  = ~w_req_empty & (r_cnt < CntWidth'(RespDepth));
  assign w_grant    = net_req_o & net_gnt_i;
  assign w_resp_pop = resp_valid_o & resp_ready_i;

  // r_rst_d marks the first cycle after reset, when the network may still
  // deliver an rvld belonging to a pre-reset grant; that beat is discarded.
  assign w_rvld_take = net_rvld_i & ~r_rst_d & (r_cnt != '0) & ~w_resp_full;
  assign w_rvld_bad  = net_rvld_i & ~r_rst_d & ((r_cnt == '0) | w_resp_full);

  tcdm_shim_fifo #(
    .WIDTH (RespDataWidth),
    .DEPTH (RespDepth),
    .CntW  (RespUseW)
  ) u_resp_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_rvld_take),
    .i_data  (net_rdata_i),
    .i_pop   (resp_ready_i),
    .o_data  (resp_data_o),
    .o_full  (w_resp_full),
    .o_empty (w_resp_empty),
    .o_usage (w_resp_usage)
  );

  assign resp_valid_o  = ~w_resp_empty;
  assign outstanding_o = r_cnt;
  assign err_o         = r_err;

  always_ff @(posedge clk_i) begin
    r_rst_d <= rst_i;
  end

  // A credit is held from grant until the core pops the matching response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      case ({w_grant, w_resp_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_rvld_bad) r_err <= 1'b1;
    end
  end

  a_cnt_range: assert property (@(posedge clk_i) disable iff (rst_i)
    r_cnt <= CntWidth'(RespDepth));

  a_credit_cover: assert property (@(posedge clk_i) disable iff (rst_i)
    int'(w_resp_usage) <= int'(r_cnt));

  a_req_usage: assert property (@(posedge clk_i) disable iff (rst_i)
    int'(w_req_usage) <= int'(ReqDepth));

  a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (net_req_o & ~net_gnt_i) |=> (net_req_o && $stable(net_add_o) && $stable(net_data_o)));

endmodule

// File: tb/tb_tcdm_master_shim.sv
module tb_tcdm_master_shim;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, resp_ready, gnt, force_rvld;
  logic [4:0]  req_add;
  logic [31:0] req_data, force_rdata;

  // Instance A: RespDepth=2
  logic        a_req_ready, a_resp_valid, a_net_req, a_err, a_rvld_m, a_rvld;
  logic [31:0] a_resp_data, a_net_data, a_rdata_m, a_rdata;
  logic [4:0]  a_net_add;
  logic [1:0]  a_out;
  // Instance B: RespDepth=3
  logic        b_req_ready, b_resp_valid, b_net_req, b_err, b_rvld_m, b_rvld;
  logic [31:0] b_resp_data, b_net_data, b_rdata_m, b_rdata;
  logic [4:0]  b_net_add;
  logic [1:0]  b_out;

  int errs = 0;
  int checks = 0;

  tcdm_master_shim #(.ReqDepth(2), .RespDepth(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(a_req_ready),
    .req_add_i(req_add), .req_data_i(req_data), .resp_valid_o(a_resp_valid),
    .resp_ready_i(resp_ready), .resp_data_o(a_resp_data), .net_req_o(a_net_req),
    .net_gnt_i(gnt), .net_add_o(a_net_add), .net_data_o(a_net_data),
    .net_rdata_i(a_rdata), .net_rvld_i(a_rvld), .outstanding_o(a_out), .err_o(a_err)
  );

  tcdm_master_shim #(.ReqDepth(2), .RespDepth(3)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(b_req_ready),
    .req_add_i(req_add), .req_data_i(req_data), .resp_valid_o(b_resp_valid),
    .resp_ready_i(resp_ready), .resp_data_o(b_resp_data), .net_req_o(b_net_req),
    .net_gnt_i(gnt), .net_add_o(b_net_add), .net_data_o(b_net_data),
    .net_rdata_i(b_rdata), .net_rvld_i(b_rvld), .outstanding_o(b_out), .err_o(b_err)
  );

  // Network model: response one cycle after grant, rdata = wdata + 0xDE08.
  always_ff @(posedge clk) begin
    a_rvld_m  <= a_net_req & gnt;
    a_rdata_m <= a_net_data + 32'hDE08;
    b_rvld_m  <= b_net_req & gnt;
    b_rdata_m <= b_net_data + 32'hDE08;
  end
  assign a_rvld  = a_rvld_m | force_rvld;
  assign a_rdata = force_rvld ? force_rdata : a_rdata_m;
  assign b_rvld  = b_rvld_m | force_rvld;
  assign b_rdata = force_rvld ? force_rdata : b_rdata_m;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; gnt = 1'b0;
    force_rvld = 1'b0; force_rdata = '0; req_add = '0; req_data = '0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; gnt = 1'b0;
    force_rvld = 1'b0; force_rdata = '0; req_add = '0; req_data = '0;
    tick; tick;
    checks++; if (a_req_ready !== 1'b1) begin errs++; $display("FAIL reset_req_ready: got %b want 1", a_req_ready); end
    checks++; if (a_resp_valid !== 1'b0) begin errs++; $display("FAIL reset_resp_valid: got %b want 0", a_resp_valid); end
    checks++; if (a_net_req !== 1'b0) begin errs++; $display("FAIL reset_net_req: got %b want 0", a_net_req); end
    checks++; if (a_out !== 2'd0) begin errs++; $display("FAIL reset_outstanding: got %0d want 0", a_out); end
    checks++; if (a_err !== 1'b0) begin errs++; $display("FAIL reset_err: got %b want 0", a_err); end
    rst = 1'b0;
  endtask

  task automatic test_single_read;
    do_reset;
    req_valid = 1'b1; req_add = 5'd5; req_data = 32'hA5; gnt = 1'b1; resp_ready = 1'b0;
    checks++; if (a_net_req !== 1'b0) begin errs++; $display("FAIL single_c0_net_req: got %b want 0", a_net_req); end
    tick;
    req_valid = 1'b0;
    checks++; if (a_net_req !== 1'b1) begin errs++; $display("FAIL single_c1_net_req: got %b want 1", a_net_req); end
    checks++; if (a_net_add !== 5'd5) begin errs++; $display("FAIL single_c1_add: got %0d want 5", a_net_add); end
    checks++; if (a_net_data !== 32'hA5) begin errs++; $display("FAIL single_c1_data: got %h want a5", a_net_data); end
    tick;
    checks++; if (a_resp_valid !== 1'b0) begin errs++; $display("FAIL single_c2_resp_valid: got %b want 0", a_resp_valid); end
    checks++; if (a_out !== 2'd1) begin errs++; $display("FAIL single_c2_outstanding: got %0d want 1", a_out); end
    tick;
    checks++; if (a_resp_valid !== 1'b1) begin errs++; $display("FAIL single_c3_resp_valid: got %b want 1", a_resp_valid); end
    checks++; if (a_resp_data !== 32'hDEAD) begin errs++; $display("FAIL single_c3_resp_data: got %h want dead", a_resp_data); end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0; gnt = 1'b0;
    checks++; if (a_out !== 2'd0) begin errs++; $display("FAIL single_outstanding_after_pop: got %0d want 0", a_out); end
    checks++; if (a_resp_valid !== 1'b0) begin errs++; $display("FAIL single_resp_valid_after_pop: got %b want 0", a_resp_valid); end
  endtask

  task automatic test_credits;
    int pushed, grants, got;
    do_reset;
    gnt = 1'b1; resp_ready = 1'b0; pushed = 0; grants = 0;
    for (int c = 0; c < 10; c++) begin
      if (a_net_req === 1'b1) grants++;
      req_valid = (pushed < 4); req_add = pushed[4:0]; req_data = 32'h100 + pushed;
      if (req_valid && a_req_ready === 1'b1) pushed++;
      tick;
    end
    req_valid = 1'b0;
    checks++; if (grants != 2) begin errs++; $display("FAIL credits_grants: got %0d want 2", grants); end
    checks++; if (pushed != 4) begin errs++; $display("FAIL credits_pushed: got %0d want 4", pushed); end
    checks++; if (a_net_req !== 1'b0) begin errs++; $display("FAIL credits_net_req_blocked: got %b want 0", a_net_req); end
    checks++; if (a_out !== 2'd2) begin errs++; $display("FAIL credits_outstanding: got %0d want 2", a_out); end
    checks++; if (a_req_ready !== 1'b0) begin errs++; $display("FAIL credits_req_ready: got %b want 0", a_req_ready); end
    checks++; if (a_resp_valid !== 1'b1 || a_resp_data !== 32'h100 + 32'hDE08)
      begin errs++; $display("FAIL credits_first_resp: got v=%b d=%h want v=1 d=%h", a_resp_valid, a_resp_data, 32'h100 + 32'hDE08); end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    checks++; if (a_net_req !== 1'b1) begin errs++; $display("FAIL credits_net_req_rise: got %b want 1", a_net_req); end
    checks++; if (a_out !== 2'd1) begin errs++; $display("FAIL credits_outstanding_after_pop: got %0d want 1", a_out); end
    resp_ready = 1'b1; got = 1;
    for (int c = 0; c < 30 && got < 4; c++) begin
      if (a_resp_valid === 1'b1) begin
        checks++; if (a_resp_data !== 32'h100 + got + 32'hDE08)
          begin errs++; $display("FAIL credits_resp_%0d: got %h want %h", got, a_resp_data, 32'h100 + got + 32'hDE08); end
        got++;
      end
      tick;
    end
    resp_ready = 1'b0; gnt = 1'b0;
    checks++; if (got != 4) begin errs++; $display("FAIL credits_resp_count: got %0d want 4", got); end
    checks++; if (a_out !== 2'd0) begin errs++; $display("FAIL credits_drained: got %0d want 0", a_out); end
  endtask

  task automatic test_grant_stall;
    logic ok;
    int got;
    do_reset;
    gnt = 1'b0; resp_ready = 1'b0;
    req_valid = 1'b1; req_add = 5'd10; req_data = 32'h200;
    tick;
    checks++; if (a_req_ready !== 1'b1) begin errs++; $display("FAIL stall_ready_after_1: got %b want 1", a_req_ready); end
    req_add = 5'd11; req_data = 32'h201;
    tick;
    req_add = 5'd12; req_data = 32'h202;
    checks++; if (a_req_ready !== 1'b0) begin errs++; $display("FAIL stall_ready_after_2: got %b want 0", a_req_ready); end
    checks++; if (a_net_req !== 1'b1 || a_net_add !== 5'd10 || a_net_data !== 32'h200)
      begin errs++; $display("FAIL stall_head: got req=%b add=%0d data=%h want 1/10/200", a_net_req, a_net_add, a_net_data); end
    ok = 1'b1;
    repeat (4) begin
      tick;
      if (a_net_req !== 1'b1 || a_net_add !== 5'd10 || a_net_data !== 32'h200 || a_req_ready !== 1'b0) ok = 1'b0;
    end
    checks++; if (ok !== 1'b1) begin errs++; $display("FAIL stall_stable: got add=%0d data=%h want 10/200 held", a_net_add, a_net_data); end
    gnt = 1'b1;
    tick;
    checks++; if (a_req_ready !== 1'b1) begin errs++; $display("FAIL stall_ready_after_grant: got %b want 1", a_req_ready); end
    checks++; if (a_net_add !== 5'd11) begin errs++; $display("FAIL stall_next_head: got %0d want 11", a_net_add); end
    tick;
    req_valid = 1'b0;
    resp_ready = 1'b1; got = 0;
    for (int c = 0; c < 30 && got < 3; c++) begin
      if (a_resp_valid === 1'b1) begin
        checks++; if (a_resp_data !== 32'h200 + got + 32'hDE08)
          begin errs++; $display("FAIL stall_resp_%0d: got %h want %h", got, a_resp_data, 32'h200 + got + 32'hDE08); end
        got++;
      end
      tick;
    end
    resp_ready = 1'b0; gnt = 1'b0;
    checks++; if (got != 3) begin errs++; $display("FAIL stall_resp_count: got %0d want 3", got); end
  endtask

  task automatic test_throughput;
    logic exp_v;
    do_reset;
    gnt = 1'b1; resp_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      exp_v = (c >= 3 && c < 19);
      checks++; if (b_resp_valid !== exp_v)
        begin errs++; $display("FAIL tput_valid_c%0d: got %b want %b", c, b_resp_valid, exp_v); end
      if (exp_v) begin
        checks++; if (b_resp_data !== 32'h300 + (c - 3) + 32'hDE08)
          begin errs++; $display("FAIL tput_data_c%0d: got %h want %h", c, b_resp_data, 32'h300 + (c - 3) + 32'hDE08); end
      end
      req_valid = (c < 16); req_add = c[4:0]; req_data = 32'h300 + c;
      tick;
    end
    req_valid = 1'b0; gnt = 1'b0; resp_ready = 1'b0;
    checks++; if (b_out !== 2'd0 || b_err !== 1'b0)
      begin errs++; $display("FAIL tput_end: got out=%0d err=%b want 0/0", b_out, b_err); end
  endtask

  task automatic test_protocol_error;
    do_reset;
    tick;
    checks++; if (a_err !== 1'b0) begin errs++; $display("FAIL perr_before: got %b want 0", a_err); end
    force_rvld = 1'b1; force_rdata = 32'h1234;
    tick;
    force_rvld = 1'b0;
    checks++; if (a_err !== 1'b1) begin errs++; $display("FAIL perr_set: got %b want 1", a_err); end
    checks++; if (a_resp_valid !== 1'b0) begin errs++; $display("FAIL perr_no_push: got %b want 0", a_resp_valid); end
    repeat (3) tick;
    checks++; if (a_err !== 1'b1) begin errs++; $display("FAIL perr_sticky: got %b want 1", a_err); end
    checks++; if (a_resp_valid !== 1'b0) begin errs++; $display("FAIL perr_still_empty: got %b want 0", a_resp_valid); end
  endtask

  task automatic test_reset_mid;
    int pushed;
    logic found;
    do_reset;
    gnt = 1'b1; resp_ready = 1'b0; pushed = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = (pushed < 4); req_add = pushed[4:0]; req_data = 32'h400 + pushed;
      if (req_valid && a_req_ready === 1'b1) pushed++;
      tick;
    end
    req_valid = 1'b0;
    checks++; if (a_out !== 2'd2 || a_resp_valid !== 1'b1 || a_req_ready !== 1'b0)
      begin errs++; $display("FAIL rmid_setup: got out=%0d rv=%b rdy=%b want 2/1/0", a_out, a_resp_valid, a_req_ready); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    force_rvld = 1'b1; force_rdata = 32'hBAD;
    checks++; if (a_req_ready !== 1'b1) begin errs++; $display("FAIL rmid_req_ready: got %b want 1", a_req_ready); end
    checks++; if (a_resp_valid !== 1'b0) begin errs++; $display("FAIL rmid_resp_valid: got %b want 0", a_resp_valid); end
    checks++; if (a_net_req !== 1'b0) begin errs++; $display("FAIL rmid_net_req: got %b want 0", a_net_req); end
    checks++; if (a_out !== 2'd0) begin errs++; $display("FAIL rmid_outstanding: got %0d want 0", a_out); end
    tick;
    force_rvld = 1'b0;
    checks++; if (a_err !== 1'b0) begin errs++; $display("FAIL rmid_stray_err: got %b want 0", a_err); end
    checks++; if (a_resp_valid !== 1'b0) begin errs++; $display("FAIL rmid_stray_dropped: got %b want 0", a_resp_valid); end
    req_valid = 1'b1; req_add = 5'd7; req_data = 32'h77;
    tick;
    req_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (a_resp_valid === 1'b1) found = 1'b1;
      else tick;
    end
    checks++; if (found !== 1'b1) begin errs++; $display("FAIL rmid_resp_timeout: got none want a response"); end
    checks++; if (a_resp_data !== 32'h77 + 32'hDE08)
      begin errs++; $display("FAIL rmid_resp_data: got %h want %h", a_resp_data, 32'h77 + 32'hDE08); end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0; gnt = 1'b0;
    checks++; if (a_out !== 2'd0 || a_err !== 1'b0)
      begin errs++; $display("FAIL rmid_after: got out=%0d err=%b want 0/0", a_out, a_err); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; gnt = 1'b0;
    force_rvld = 1'b0; force_rdata = '0; req_add = '0; req_data = '0;
    test_reset;
    test_single_read;
    test_credits;
    test_grant_stall;
    test_throughput;
    test_protocol_error;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
